// File: rtl/periodic_read_requester.sv
// Periodic-read injection source: an interval timer ticks, and each tick requests one bank
// (round-robin) from its command generator. The request is held until that bank accepts.
module periodic_read_requester #(
  parameter int unsigned NUM_BANKS      = 16,
  parameter int unsigned ROW_WIDTH      = 18,
  parameter int unsigned INTERVAL_WIDTH = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic [INTERVAL_WIDTH-1:0]      cfg_interval_i,
  input  logic [NUM_BANKS-1:0]           bank_open_i,
  input  logic [NUM_BANKS*ROW_WIDTH-1:0] bank_open_row_i,
  input  logic [NUM_BANKS-1:0]           per_rd_accept_i,
  output logic                           per_rd_req_o,
  output logic [NUM_BANKS-1:0]           inject_select_o,
  output logic                           inject_open_o,
  output logic [ROW_WIDTH-1:0]           inject_row_o,
  output logic                           busy_o,
  output logic [CNT_WIDTH-1:0]           issued_count_o,
  output logic [CNT_WIDTH-1:0]           overrun_count_o
);

  localparam int unsigned PtrW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [PtrW-1:0] LastBank = PtrW'(NUM_BANKS - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e                    state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
  logic [PtrW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      req_q, req_d;
  logic [NUM_BANKS-1:0]      select_q, select_d;
  logic                      open_q, open_d;
  logic [ROW_WIDTH-1:0]      row_q, row_d;
  logic [CNT_WIDTH-1:0]      issued_q, issued_d;
  logic [CNT_WIDTH-1:0]      overrun_q, overrun_d;

  logic                 run;
  logic                 tick;
  logic                 accept;
  logic                 sel_open;
  logic [ROW_WIDTH-1:0] sel_row;

  assign run    = enable_i && (cfg_interval_i != '0);
  assign tick   = run && (interval_q == cfg_interval_i - INTERVAL_WIDTH'(1));
  assign accept = per_rd_accept_i[rr_ptr_q];

  // A counter already past a shrunken interval simply rolls over at its max value.
  assign interval_d = (!run || tick) ? '0 : interval_q + INTERVAL_WIDTH'(1);

  always_comb begin
    sel_row  = '0;
    sel_open = bank_open_i[rr_ptr_q];
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (rr_ptr_q == PtrW'(b)) begin
        sel_row = bank_open_row_i[b*ROW_WIDTH +: ROW_WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      interval_q <= '0;
      rr_ptr_q   <= '0;
      req_q      <= 1'b0;
      select_q   <= '0;
      open_q     <= 1'b0;
      row_q      <= '0;
      issued_q   <= '0;
      overrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      rr_ptr_q   <= rr_ptr_d;
      req_q      <= req_d;
      select_q   <= select_d;
      open_q     <= open_d;
      row_q      <= row_d;
      issued_q   <= issued_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StReq;
      StReq:   if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered output next values
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    req_d     = req_q;
    select_d  = select_q;
    open_d    = open_q;
    row_d     = row_q;
    issued_d  = issued_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          req_d    = 1'b1;
          select_d = NUM_BANKS'(1) << rr_ptr_q;
          open_d   = sel_open;
          row_d    = sel_open ? sel_row : '0;
        end
      end
      StReq: begin
        // Ticks during an outstanding request are dropped, even when it is being accepted.
        if (tick && (overrun_q != '1)) overrun_d = overrun_q + CNT_WIDTH'(1);
        if (accept) begin
          req_d    = 1'b0;
          select_d = '0;
          open_d   = 1'b0;
          row_d    = '0;
          rr_ptr_d = (rr_ptr_q == LastBank) ? '0 : rr_ptr_q + PtrW'(1);
          if (issued_q != '1) issued_d = issued_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign per_rd_req_o    = req_q;
  assign inject_select_o = select_q;
  assign inject_open_o   = open_q;
  assign inject_row_o    = row_q;
  assign busy_o          = (state_q == StReq);
  assign issued_count_o  = issued_q;
  assign overrun_count_o = overrun_q;

endmodule

// File: tb/tb_periodic_read_requester.sv
// Directed bench for periodic_read_requester; a second instance with 4-bit counters
// shares the stimulus to observe saturation.
module tb_periodic_read_requester;

  localparam int NB = 16;
  localparam int RW = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [15:0]      cfg_interval;
  logic [NB-1:0]    bank_open;
  logic [NB*RW-1:0] bank_open_row;
  logic [NB-1:0]    accept;

  logic          req, open, busy;
  logic [NB-1:0] sel;
  logic [RW-1:0] row;
  logic [15:0]   issued, overrun;

  logic          req4, open4, busy4;
  logic [NB-1:0] sel4;
  logic [RW-1:0] row4;
  logic [3:0]    issued4, overrun4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  periodic_read_requester dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .cfg_interval_i(cfg_interval),
    .bank_open_i(bank_open), .bank_open_row_i(bank_open_row), .per_rd_accept_i(accept),
    .per_rd_req_o(req), .inject_select_o(sel), .inject_open_o(open), .inject_row_o(row),
    .busy_o(busy), .issued_count_o(issued), .overrun_count_o(overrun)
  );

  periodic_read_requester #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .cfg_interval_i(cfg_interval),
    .bank_open_i(bank_open), .bank_open_row_i(bank_open_row), .per_rd_accept_i(accept),
    .per_rd_req_o(req4), .inject_select_o(sel4), .inject_open_o(open4), .inject_row_o(row4),
    .busy_o(busy4), .issued_count_o(issued4), .overrun_count_o(overrun4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, output int n, output bit found);
    n = 0;
    found = (req === 1'b1);
    while (!found && n < max) begin
      step();
      n++;
      found = (req === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if ({req, sel, open, row, busy, issued, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b sel=%h open=%b row=%h busy=%b iss=%0d ovr=%0d",
               req, sel, open, row, busy, issued, overrun);
    end
    tests++;
    if ({req4, sel4, busy4, issued4, overrun4} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_w4: req=%b sel=%h iss=%0d ovr=%0d", req4, sel4, issued4, overrun4);
    end
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (req !== (i == 4)) begin
        fails++;
        $display("FAIL first_req_latency cycle %0d: req=%b expected %b", i, req, (i == 4));
      end
    end
  endtask

  task automatic test_interval();
    int n;
    bit found;
    for (int i = 0; i < 17; i++) begin
      wait_req(8, n, found);
      tests++;
      if (!found || n != ((i == 0) ? 0 : 3)) begin
        fails++;
        $display("FAIL interval_period req %0d: found=%b cycles=%0d expected %0d",
                 i, found, n, (i == 0) ? 0 : 3);
      end
      tests++;
      if (sel !== (16'h0001 << (i % 16)) || busy !== 1'b1) begin
        fails++;
        $display("FAIL rr_select req %0d: sel=%h busy=%b expected %h", i, sel, busy,
                 16'h0001 << (i % 16));
      end
      accept = sel;
      step();
      accept = '0;
      tests++;
      if (req !== 1'b0 || sel !== '0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL accept_deassert req %0d: req=%b sel=%h busy=%b", i, req, sel, busy);
      end
    end
    tests++;
    if (issued !== 16'd17) begin
      fails++;
      $display("FAIL issued_count: got %0d expected 17", issued);
    end
    tests++;
    if (issued4 !== 4'd15) begin
      fails++;
      $display("FAIL issued_saturate_w4: got %0d expected 15", issued4);
    end
  endtask

  task automatic test_open_close();
    int n;
    bit found;
    logic          exp_open [1:4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [RW-1:0] exp_row  [1:4] = '{18'h0, 18'h25555, 18'h1ABCD, 18'h0};
    for (int b = 1; b <= 4; b++) begin
      wait_req(8, n, found);
      tests++;
      if (!found || sel !== (16'h0001 << b) || open !== exp_open[b] || row !== exp_row[b]) begin
        fails++;
        $display("FAIL open_close bank %0d: found=%b sel=%h open=%b row=%h expected open=%b row=%h",
                 b, found, sel, open, row, exp_open[b], exp_row[b]);
      end
      if (b == 3) begin
        bank_open[3] = 1'b0;
        bank_open_row[3*RW +: RW] = '0;
        step();
        tests++;
        if (req !== 1'b1 || open !== 1'b1 || row !== 18'h1ABCD) begin
          fails++;
          $display("FAIL held_payload: req=%b open=%b row=%h expected 1 1 1abcd", req, open, row);
        end
        bank_open[3] = 1'b1;
        bank_open_row[3*RW +: RW] = 18'h1ABCD;
      end
      accept = sel;
      step();
      accept = '0;
      tests++;
      if ({req, sel, open, row} !== '0) begin
        fails++;
        $display("FAIL idle_clears bank %0d: req=%b sel=%h open=%b row=%h", b, req, sel, open, row);
      end
    end
  endtask

  task automatic test_stall_overrun();
    int n;
    bit found;
    enable = 1'b0;
    step();
    step();
    cfg_interval = 16'd2;
    enable = 1'b1;
    wait_req(8, n, found);
    tests++;
    if (!found || n != 2 || sel !== 16'h0020) begin
      fails++;
      $display("FAIL stall_first_req: found=%b cycles=%0d sel=%h expected 2 0020", found, n, sel);
    end
    for (int k = 1; k <= 7; k++) begin
      accept = (k == 3) ? 16'h0040 : 16'h0000;
      step();
      accept = '0;
      tests++;
      if (req !== 1'b1 || sel !== 16'h0020 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold cycle %0d: req=%b sel=%h busy=%b", k, req, sel, busy);
      end
    end
    tests++;
    if (overrun !== 16'd3 || overrun4 !== 4'd3 || issued !== 16'd21) begin
      fails++;
      $display("FAIL overrun_count: ovr=%0d ovr4=%0d iss=%0d expected 3 3 21",
               overrun, overrun4, issued);
    end
  endtask

  task automatic test_handshake_edge();
    int n;
    bit found;
    accept = 16'h0020;
    step();
    accept = '0;
    tests++;
    if (req !== 1'b0 || overrun !== 16'd4 || issued !== 16'd22) begin
      fails++;
      $display("FAIL tick_and_accept: req=%b ovr=%0d iss=%0d expected 0 4 22", req, overrun, issued);
    end
    wait_req(8, n, found);
    tests++;
    if (!found || n != 2 || sel !== 16'h0040) begin
      fails++;
      $display("FAIL next_req_after_edge: found=%b cycles=%0d sel=%h expected 2 0040", found, n, sel);
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (req !== 1'b1 || sel !== 16'h0040) begin
        fails++;
        $display("FAIL disable_keeps_req cycle %0d: req=%b sel=%h", k, req, sel);
      end
    end
    accept = 16'h0040;
    step();
    accept = '0;
    tests++;
    if (req !== 1'b0 || issued !== 16'd23 || overrun !== 16'd4) begin
      fails++;
      $display("FAIL disabled_accept: req=%b iss=%0d ovr=%0d expected 0 23 4", req, issued, overrun);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (req !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL disabled_stays_idle cycle %0d: req=%b busy=%b", k, req, busy);
      end
    end
  endtask

  task automatic test_saturation_reset();
    cfg_interval = 16'd1;
    enable = 1'b1;
    step();
    tests++;
    if (req !== 1'b1 || sel !== 16'h0080) begin
      fails++;
      $display("FAIL interval1_req: req=%b sel=%h expected 1 0080", req, sel);
    end
    for (int k = 0; k < 20; k++) step();
    tests++;
    if (overrun !== 16'd24 || overrun4 !== 4'd15) begin
      fails++;
      $display("FAIL overrun_saturate: ovr=%0d ovr4=%0d expected 24 15", overrun, overrun4);
    end
    tests++;
    if (req !== 1'b1 || sel !== 16'h0080 || issued4 !== 4'd15) begin
      fails++;
      $display("FAIL stall_before_rst: req=%b sel=%h iss4=%0d", req, sel, issued4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({req, sel, open, row, busy, issued, overrun, overrun4, issued4} !== '0) begin
      fails++;
      $display("FAIL mid_req_reset: req=%b sel=%h busy=%b iss=%0d ovr=%0d ovr4=%0d",
               req, sel, busy, issued, overrun, overrun4);
    end
    step();
    tests++;
    if (req !== 1'b1 || sel !== 16'h0001 || open !== 1'b0) begin
      fails++;
      $display("FAIL rr_ptr_after_reset: req=%b sel=%h open=%b expected 1 0001 0", req, sel, open);
    end
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    cfg_interval  = 16'd4;
    accept        = '0;
    bank_open     = 16'h000C;
    bank_open_row = '0;
    bank_open_row[1*RW +: RW] = 18'h3FFFF;
    bank_open_row[2*RW +: RW] = 18'h25555;
    bank_open_row[3*RW +: RW] = 18'h1ABCD;
    bank_open_row[4*RW +: RW] = 18'h00123;
    test_reset();
    test_interval();
    test_open_close();
    test_stall_overrun();
    test_handshake_edge();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
